// File: rtl/clock_pkg.sv
// Shared types, constants and wrap helpers for the clock_alarm core.
package clock_pkg;

    localparam logic [2:0] KEY_S1 = 3'd1;
    localparam logic [2:0] KEY_S2 = 3'd2;
    localparam logic [2:0] KEY_S3 = 3'd3;
    localparam logic [2:0] KEY_S4 = 3'd4;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_SET_TIME,
        ST_SET_ALARM
    } state_e;

    typedef enum logic [1:0] {
        FLD_SEC,
        FLD_MIN,
        FLD_HOUR
    } field_e;

    localparam logic [2:0] LED_IDLE  = 3'b111;
    localparam logic [2:0] LED_SEC   = 3'b110;
    localparam logic [2:0] LED_MIN   = 3'b101;
    localparam logic [2:0] LED_HOUR  = 3'b011;
    localparam logic [2:0] LED_BLINK = 3'b000;

    localparam logic [5:0] MAX_MS = 6'd59;
    localparam logic [4:0] MAX_HR = 5'd23;

    localparam int DATA_W   = 21;
    localparam int SEC_LSB  = 0;
    localparam int MIN_LSB  = 7;
    localparam int HOUR_LSB = 14;

    function automatic logic [5:0] ms_inc(input logic [5:0] v);
        return (v >= MAX_MS) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [5:0] ms_dec(input logic [5:0] v);
        return (v == 6'd0) ? MAX_MS : v - 6'd1;
    endfunction

    function automatic logic [4:0] hr_inc(input logic [4:0] v);
        return (v >= MAX_HR) ? 5'd0 : v + 5'd1;
    endfunction

    function automatic logic [4:0] hr_dec(input logic [4:0] v);
        return (v == 5'd0) ? MAX_HR : v - 5'd1;
    endfunction

    function automatic logic [2:0] field_led(input field_e f);
        case (f)
            FLD_SEC: return LED_SEC;
            FLD_MIN: return LED_MIN;
            default: return LED_HOUR;
        endcase
    endfunction

endpackage

// File: rtl/clock_alarm_tick_div.sv
// Seconds prescaler: one-cycle tick every TICK_DIV clocks, count held at 0 by hold_i.
module tick_div #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic hold_i,
    output logic tick_o
);

    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign tick_o = !hold_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (hold_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/clock_alarm.sv
// 24-hour time-of-day core with settable alarm, snooze and 12/24h display.
module clock_alarm
    import clock_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_MIN = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        key_val,
    input  logic              mode_12h,
    output logic [DATA_W-1:0] data,
    output logic [2:0]        led,
    output logic              pm,
    output logic              alarm_en,
    output logic              ring
);

    state_e     state_q, state_d;
    field_e     field_q, field_d;
    logic [5:0] sec_q, sec_d, min_q, min_d;
    logic [4:0] hour_q, hour_d;
    logic [5:0] al_min_q, al_min_d;
    logic [4:0] al_hour_q, al_hour_d;
    logic       en_q, en_d, ring_q, ring_d;
    logic [7:0] ring_cnt_q, ring_cnt_d;
    logic       snz_q, snz_d;
    logic [5:0] snz_min_q, snz_min_d;
    logic [4:0] snz_hour_q, snz_hour_d;

    logic       tick, hold;
    logic [5:0] t_sec, t_min, tgt_min;
    logic [4:0] t_hour, tgt_hour;
    logic       hit_alarm, hit_snz, match, ringing;

    assign hold = (state_q == ST_SET_TIME);

    tick_div #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk_i (clk),
        .rst_i (rst),
        .hold_i(hold),
        .tick_o(tick)
    );

    // time as it will be after this edge's tick
    always_comb begin
        t_sec  = sec_q;
        t_min  = min_q;
        t_hour = hour_q;
        if (tick) begin
            t_sec = ms_inc(sec_q);
            if (sec_q == MAX_MS) begin
                t_min = ms_inc(min_q);
                if (min_q == MAX_MS) begin
                    t_hour = hr_inc(hour_q);
                end
            end
        end
    end

    always_comb begin
        tgt_hour = t_hour;
        tgt_min  = t_min + 6'(SNOOZE_MIN);
        if (t_min >= 6'(60 - SNOOZE_MIN)) begin
            tgt_min  = t_min - 6'(60 - SNOOZE_MIN);
            tgt_hour = hr_inc(t_hour);
        end
    end

    assign hit_alarm = (t_min == al_min_q) && (t_hour == al_hour_q);
    assign hit_snz   = snz_q && (t_min == snz_min_q) && (t_hour == snz_hour_q);
    assign match     = tick && (t_sec == 6'd0) && en_q
                       && (state_q != ST_SET_TIME) && (hit_alarm || hit_snz);
    assign ringing   = ring_q || match;

    always_comb begin
        state_d    = state_q;
        field_d    = field_q;
        sec_d      = t_sec;
        min_d      = t_min;
        hour_d     = t_hour;
        al_min_d   = al_min_q;
        al_hour_d  = al_hour_q;
        en_d       = en_q;
        ring_d     = ring_q;
        ring_cnt_d = ring_cnt_q;
        snz_d      = snz_q;
        snz_min_d  = snz_min_q;
        snz_hour_d = snz_hour_q;

        if (match) begin
            ring_d     = 1'b1;
            ring_cnt_d = 8'(RING_SEC);
            if (hit_snz) begin
                snz_d = 1'b0;
            end
        end else if (tick && ring_q) begin
            ring_cnt_d = ring_cnt_q - 8'd1;
            if (ring_cnt_q <= 8'd1) begin
                ring_d = 1'b0;
            end
        end

        case (state_q)
            ST_RUN: begin
                if (ringing && key_val == KEY_S1) begin
                    ring_d     = 1'b0;
                    snz_d      = 1'b1;
                    snz_min_d  = tgt_min;
                    snz_hour_d = tgt_hour;
                end else if (ringing && key_val == KEY_S4) begin
                    ring_d = 1'b0;
                    snz_d  = 1'b0;
                end else begin
                    case (key_val)
                        KEY_S1: begin
                            en_d = !en_q;
                            if (en_q) begin
                                ring_d = 1'b0;
                                snz_d  = 1'b0;
                            end
                        end
                        KEY_S2: begin
                            state_d = ST_SET_TIME;
                            field_d = FLD_SEC;
                        end
                        KEY_S3: begin
                            state_d = ST_SET_ALARM;
                            field_d = FLD_MIN;
                        end
                        default: ;
                    endcase
                end
            end
            ST_SET_TIME: begin
                case (key_val)
                    KEY_S2: begin
                        case (field_q)
                            FLD_SEC: field_d = FLD_MIN;
                            FLD_MIN: field_d = FLD_HOUR;
                            default: field_d = FLD_SEC;
                        endcase
                    end
                    KEY_S3: begin
                        case (field_q)
                            FLD_SEC: sec_d  = ms_inc(sec_q);
                            FLD_MIN: min_d  = ms_inc(min_q);
                            default: hour_d = hr_inc(hour_q);
                        endcase
                    end
                    KEY_S1: begin
                        case (field_q)
                            FLD_SEC: sec_d  = ms_dec(sec_q);
                            FLD_MIN: min_d  = ms_dec(min_q);
                            default: hour_d = hr_dec(hour_q);
                        endcase
                    end
                    KEY_S4: state_d = ST_RUN;
                    default: ;
                endcase
            end
            ST_SET_ALARM: begin
                case (key_val)
                    KEY_S2: field_d = (field_q == FLD_MIN) ? FLD_HOUR : FLD_MIN;
                    KEY_S3: begin
                        if (field_q == FLD_MIN) al_min_d = ms_inc(al_min_q);
                        else al_hour_d = hr_inc(al_hour_q);
                    end
                    KEY_S1: begin
                        if (field_q == FLD_MIN) al_min_d = ms_dec(al_min_q);
                        else al_hour_d = hr_dec(al_hour_q);
                    end
                    KEY_S4: state_d = ST_RUN;
                    default: ;
                endcase
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            field_q    <= FLD_SEC;
            sec_q      <= '0;
            min_q      <= '0;
            hour_q     <= '0;
            al_min_q   <= '0;
            al_hour_q  <= '0;
            en_q       <= 1'b0;
            ring_q     <= 1'b0;
            ring_cnt_q <= '0;
            snz_q      <= 1'b0;
            snz_min_q  <= '0;
            snz_hour_q <= '0;
        end else begin
            state_q    <= state_d;
            field_q    <= field_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hour_q     <= hour_d;
            al_min_q   <= al_min_d;
            al_hour_q  <= al_hour_d;
            en_q       <= en_d;
            ring_q     <= ring_d;
            ring_cnt_q <= ring_cnt_d;
            snz_q      <= snz_d;
            snz_min_q  <= snz_min_d;
            snz_hour_q <= snz_hour_d;
        end
    end

    logic [5:0] disp_sec, disp_min;
    logic [4:0] disp_hour, shown_hour;

    always_comb begin
        disp_sec  = sec_q;
        disp_min  = min_q;
        disp_hour = hour_q;
        if (state_q == ST_SET_ALARM) begin
            disp_sec  = 6'd0;
            disp_min  = al_min_q;
            disp_hour = al_hour_q;
        end
        pm         = (disp_hour >= 5'd12);
        shown_hour = disp_hour;
        if (mode_12h) begin
            if (disp_hour == 5'd0) shown_hour = 5'd12;
            else if (disp_hour > 5'd12) shown_hour = disp_hour - 5'd12;
        end
        data = '0;
        data[SEC_LSB +: 6]  = disp_sec;
        data[MIN_LSB +: 6]  = disp_min;
        data[HOUR_LSB +: 5] = shown_hour;
    end

    // ringing blinks all LEDs with the seconds, over any field indication
    always_comb begin
        case (state_q)
            ST_RUN:  led = LED_IDLE;
            default: led = field_led(field_q);
        endcase
        if (ring_q) begin
            led = sec_q[0] ? LED_IDLE : LED_BLINK;
        end
    end

    assign alarm_en = en_q;
    assign ring     = ring_q;

endmodule

// File: tb/tb_clock_alarm.sv
// Directed bench for clock_alarm with a seconds-of-day reference model.
module tb_clock_alarm;

    localparam int TD = 4;
    localparam int RS = 3;
    localparam int SM = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  key_val = 3'd0;
    logic        mode_12h = 1'b0;
    logic [20:0] data;
    logic [2:0]  led;
    logic        pm, alarm_en, ring;

    int checks = 0;
    int errors = 0;

    clock_alarm #(
        .TICK_DIV  (TD),
        .RING_SEC  (RS),
        .SNOOZE_MIN(SM)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .key_val (key_val),
        .mode_12h(mode_12h),
        .data    (data),
        .led     (led),
        .pm      (pm),
        .alarm_en(alarm_en),
        .ring    (ring)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [20:0] mk(input int h, input int m, input int s);
        return (21'(h) << 14) | (21'(m) << 7) | 21'(s);
    endfunction

    // model: time as seconds-of-day, alarm and snooze as minutes-of-day
    int m_tod, m_pre, m_st, m_fld, m_alm, m_left, m_snz;
    bit m_en;
    bit m_live = 1'b0;

    function automatic int wrapi(input int v, input int n);
        return ((v % n) + n) % n;
    endfunction

    task automatic model_reset();
        m_tod = 0; m_pre = 0; m_st = 0; m_fld = 0;
        m_alm = 0; m_left = 0; m_snz = -1; m_en = 1'b0;
    endtask

    task automatic model_step(input logic [2:0] k);
        int nt, h, m, s, d;
        bit tk, mt, rg;
        if (m_st == 1) begin
            tk = 1'b0;
            m_pre = 0;
        end else begin
            tk = (m_pre == TD - 1);
            m_pre = tk ? 0 : m_pre + 1;
        end
        nt = tk ? (m_tod + 1) % 86400 : m_tod;
        mt = tk && (nt % 60 == 0) && m_en && (m_st != 1)
             && ((nt / 60 == m_alm) || (m_snz >= 0 && nt / 60 == m_snz));
        rg = (m_left > 0) || mt;
        if (mt) begin
            if (m_snz >= 0 && nt / 60 == m_snz) m_snz = -1;
            m_left = RS;
        end else if (tk && m_left > 0) begin
            m_left--;
        end
        m_tod = nt;
        d = (k == 3'd1) ? -1 : (k == 3'd3) ? 1 : 0;
        case (m_st)
            0: begin
                if (rg && k == 3'd1) begin
                    m_left = 0;
                    m_snz = (nt / 60 + SM) % 1440;
                end else if (rg && k == 3'd4) begin
                    m_left = 0;
                    m_snz = -1;
                end else if (k == 3'd1) begin
                    m_en = !m_en;
                    if (!m_en) begin m_left = 0; m_snz = -1; end
                end else if (k == 3'd2) begin
                    m_st = 1; m_fld = 0;
                end else if (k == 3'd3) begin
                    m_st = 2; m_fld = 1;
                end
            end
            1: begin
                if (k == 3'd2) m_fld = (m_fld + 1) % 3;
                else if (k == 3'd4) m_st = 0;
                else if (d != 0) begin
                    h = m_tod / 3600; m = (m_tod / 60) % 60; s = m_tod % 60;
                    case (m_fld)
                        0: s = wrapi(s + d, 60);
                        1: m = wrapi(m + d, 60);
                        default: h = wrapi(h + d, 24);
                    endcase
                    m_tod = h * 3600 + m * 60 + s;
                end
            end
            default: begin
                if (k == 3'd2) m_fld = 3 - m_fld;
                else if (k == 3'd4) m_st = 0;
                else if (d != 0) begin
                    h = m_alm / 60; m = m_alm % 60;
                    if (m_fld == 1) m = wrapi(m + d, 60);
                    else h = wrapi(h + d, 24);
                    m_alm = h * 60 + m;
                end
            end
        endcase
    endtask

    function automatic logic [26:0] exp_out();
        int h, m, s, hh;
        logic [2:0] l;
        if (m_st == 2) begin
            h = m_alm / 60; m = m_alm % 60; s = 0;
        end else begin
            h = m_tod / 3600; m = (m_tod / 60) % 60; s = m_tod % 60;
        end
        hh = !mode_12h ? h : (h == 0) ? 12 : (h > 12) ? h - 12 : h;
        if (m_left > 0) l = (m_tod % 2 == 1) ? 3'b111 : 3'b000;
        else if (m_st == 0) l = 3'b111;
        else if (m_fld == 0) l = 3'b110;
        else if (m_fld == 1) l = 3'b101;
        else l = 3'b011;
        return {mk(hh, m, s), l, (h >= 12), m_en, (m_left > 0)};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            model_reset();
            m_live = 1'b1;
        end else if (m_live) begin
            model_step(key_val);
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            #1;
            chk("model_out", {data, led, pm, alarm_en, ring}, exp_out());
        end
    end

    task automatic press(input logic [2:0] k);
        key_val = k;
        @(negedge clk);
        key_val = 3'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        key_val = 3'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_ring(input logic v, input int bound, input string nm);
        int n = 0;
        while (ring !== v && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(nm, ring, v);
    endtask

    task automatic setup_alarm();
        do_reset();
        press(3'd3);
        press(3'd3);
        chk("alarm_disp", data, mk(0, 1, 0));
        chk("alarm_led", led, 3'b101);
        press(3'd4);
        press(3'd1);
        chk("armed", alarm_en, 1'b1);
    endtask

    initial begin
        int seen;
        @(negedge clk);
        do_reset();
        chk("rst_data", data, 21'd0);
        chk("rst_led", led, 3'b111);
        chk("rst_pm_en_ring", {pm, alarm_en, ring}, 3'b000);
        idle(240);
        chk("run_1min", data, 21'h000080);

        do_reset();
        press(3'd2);
        press(3'd1);
        chk("sec_dec_wrap", data, mk(0, 0, 59));
        press(3'd2);
        press(3'd1);
        press(3'd2);
        press(3'd1);
        chk("preset", data, mk(23, 59, 59));
        chk("preset_led", led, 3'b011);
        press(3'd4);
        idle(3);
        chk("pre_tick", data, mk(23, 59, 59));
        idle(1);
        chk("day_wrap", data, mk(0, 0, 0));

        press(3'd2);
        press(3'd2);
        press(3'd2);
        press(3'd1);
        chk("hour_dec_wrap", data, mk(23, 0, 0));
        chk("hour_led", led, 3'b011);
        idle(200);
        chk("frozen", data, mk(23, 0, 0));
        press(3'd4);
        idle(3);
        chk("resume_wait", data, mk(23, 0, 0));
        idle(1);
        chk("resume_tick", data, mk(23, 0, 1));
        press(3'd5);
        press(3'd7);
        idle(8);

        setup_alarm();
        wait_ring(1'b1, 400, "ring_on");
        chk("ring_time", data, mk(0, 1, 0));
        chk("ring_led_even", led, 3'b000);
        idle(4);
        chk("ring_time1", data, mk(0, 1, 1));
        chk("ring_led_odd", led, 3'b111);
        wait_ring(1'b0, 40, "ring_off");
        chk("ring_off_time", data, mk(0, 1, 3));

        setup_alarm();
        wait_ring(1'b1, 400, "ring_on2");
        press(3'd1);
        chk("snooze_quiet", ring, 1'b0);
        wait_ring(1'b1, 1400, "snooze_ring");
        chk("snooze_time", data, mk(0, 6, 0));
        press(3'd4);
        chk("dismiss", ring, 1'b0);
        seen = 0;
        repeat (1300) begin
            @(negedge clk);
            if (ring) seen++;
        end
        chk("no_ring_11", seen, 0);

        do_reset();
        mode_12h = 1'b1;
        idle(1);
        chk("h12_midnight", data, mk(12, 0, 0));
        press(3'd2);
        press(3'd2);
        repeat (30) press(3'd3);
        chk("h12_0030", data, mk(12, 30, 0));
        chk("h12_0030_pm", pm, 1'b0);
        press(3'd2);
        repeat (13) press(3'd3);
        press(3'd2);
        press(3'd2);
        repeat (25) press(3'd1);
        chk("h12_1305", data, mk(1, 5, 0));
        chk("h12_1305_pm", pm, 1'b1);
        mode_12h = 1'b0;
        idle(1);
        chk("h24_1305", data, mk(13, 5, 0));
        press(3'd4);

        setup_alarm();
        wait_ring(1'b1, 400, "ring_on3");
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ring_data", data, 21'd0);
        chk("rst_ring_led", led, 3'b111);
        chk("rst_ring_flags", {pm, alarm_en, ring}, 3'b000);
        rst = 1'b0;
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
